gate_unit_pipe: RTL and testbench

//   Parametrised, registered bitwise gate unit; generalises the single-bit 2-input gate primitives.

---
 rtl/gate_unit_pipe.sv | 129 ++++++++++++
 tb/tb_gate_unit_pipe.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_pipe.sv
// Registered WIDTH-bit gate unit with valid/ready handshake and an
// optional OR-fold accumulate mode over ACC_LEN beats.
module gate_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [2:0]                   op,
  input  logic                         acc_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             y,
  output logic                         y_red,
  output logic                         y_and,
  output logic [$clog2(ACC_LEN+1)-1:0] beat_cnt
);

  localparam int CW = $clog2(ACC_LEN+1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN-1);
  localparam logic ACC_MULTI = (ACC_LEN > 1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] res, acc, acc_nx, y_nx;
  logic [CW-1:0]    cnt_nx;
  logic             accept, take, last, start, y_ld;

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a & b);
      3'd4: res = ~(a | b);
      3'd5: res = ~(a ^ b);
      3'd6: res = ~a;
      3'd7: res = a;
      default: res = '0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;
  assign last   = (beat_cnt == LAST);
  // IDLE and OUT both treat an accepted beat as the first of a result
  assign start  = accept && (state != ACC);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
        state_nx = (acc_en && ACC_MULTI) ? ACC : OUT;
      ACC: if (accept && last)
        state_nx = OUT;
      OUT: if (take)
        state_nx = !accept ? IDLE :
                   (acc_en && ACC_MULTI) ? ACC : OUT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE, ACC: in_ready = rst_n;
      OUT: begin
        in_ready  = rst_n && out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    y_ld   = 1'b0;
    y_nx   = acc | res;
    acc_nx = acc;
    cnt_nx = beat_cnt;
    if (start) begin
      acc_nx = res;
      y_nx   = res;
      if (acc_en) begin
        cnt_nx = CW'(1);
        y_ld   = !ACC_MULTI;
      end else begin
        cnt_nx = '0;
        y_ld   = 1'b1;
      end
    end else if (accept) begin
      acc_nx = acc | res;
      cnt_nx = beat_cnt + CW'(1);
      y_ld   = last;
    end else if (take) begin
      cnt_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      y        <= '0;
      y_red    <= 1'b0;
      y_and    <= 1'b0;
    end else begin
      acc      <= acc_nx;
      beat_cnt <= cnt_nx;
      if (y_ld) begin
        y     <= y_nx;
        y_red <= |y_nx;
        y_and <= &y_nx;
      end
    end
  end

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Directed bench for gate_unit_pipe (WIDTH=8, ACC_LEN=4).
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_gate_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       acc_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       y_red, y_and;
  logic [2:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  gate_unit_pipe #(.WIDTH(8), .ACC_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_red(y_red), .y_and(y_and),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 8'hFF; b = 8'hFF; op = 3'd0; acc_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b0
          || beat_cnt !== 3'd0) begin
        errors++;
        $display("FAIL reset%0d got ov=%b y=%h ir=%b bc=%0d exp 0 00 0 0",
                 i, out_valid, y, in_ready, beat_cnt);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b exp 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'hFF || y_and !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_accept got ov=%b y=%h ya=%b exp 1 ff 1",
               out_valid, y, y_and);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [7:0] exp_y [8];
    exp_y = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
    out_ready = 1'b1; acc_en = 1'b0; in_valid = 1'b1;
    a = 8'hF0; b = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || y !== exp_y[i] || beat_cnt !== 3'd0) begin
        errors++;
        $display("FAIL single_op%0d got ov=%b y=%h bc=%0d exp 1 %h 0",
                 i, out_valid, y, beat_cnt, exp_y[i]);
      end
      if (i == 4) begin
        checks++;
        if (y_red !== 1'b1 || y_and !== 1'b0) begin
          errors++;
          $display("FAIL single_red got yr=%b ya=%b exp 1 0", y_red, y_and);
        end
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
    a = 8'hFF; b = 8'hFF; op = 3'd0;
    step();
    a = 8'h0F; op = 3'd7;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d got %b exp 0", i, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || y !== 8'hFF || y_and !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b y=%h ya=%b exp 1 ff 1",
                 i, out_valid, y, y_and);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got %b exp 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h0F || y_and !== 1'b0) begin
      errors++;
      $display("FAIL bp_next got ov=%b y=%h ya=%b exp 1 0f 0",
               out_valid, y, y_and);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_accumulate();
    logic [7:0] va [4];
    va = '{8'h01, 8'h02, 8'h04, 8'h80};
    out_ready = 1'b0; acc_en = 1'b1; op = 3'd7; b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = va[i];
      step();
      if (i < 3) begin
        checks++;
        if (out_valid !== 1'b0 || beat_cnt !== 3'(i + 1)) begin
          errors++;
          $display("FAIL acc_beat%0d got ov=%b bc=%0d exp 0 %0d",
                   i, out_valid, beat_cnt, i + 1);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h87 || beat_cnt !== 3'd4
        || y_red !== 1'b1 || y_and !== 1'b0) begin
      errors++;
      $display("FAIL acc_result got ov=%b y=%h bc=%0d yr=%b ya=%b exp 1 87 4 1 0",
               out_valid, y, beat_cnt, y_red, y_and);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || beat_cnt !== 3'd4) begin
      errors++;
      $display("FAIL acc_hold got ov=%b bc=%0d exp 1 4", out_valid, beat_cnt);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 3'd0 || y !== 8'h87) begin
      errors++;
      $display("FAIL acc_take got ov=%b bc=%0d y=%h exp 0 0 87",
               out_valid, beat_cnt, y);
    end
  endtask

  task automatic test_acc_reset();
    out_ready = 1'b0; acc_en = 1'b1;
    in_valid = 1'b1; a = 8'h01; b = 8'h00; op = 3'd7;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (beat_cnt !== 3'd1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL accr_gap got bc=%0d ov=%b exp 1 0", beat_cnt, out_valid);
    end
    in_valid = 1'b1; a = 8'h10; b = 8'h30; op = 3'd0;
    step();
    checks++;
    if (beat_cnt !== 3'd2) begin
      errors++;
      $display("FAIL accr_beat2 got bc=%0d exp 2", beat_cnt);
    end
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (beat_cnt !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL accr_reset got bc=%0d ov=%b exp 0 0", beat_cnt, out_valid);
    end
    in_valid = 1'b1; op = 3'd7; b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 8'h40 : 8'h00;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h40 || beat_cnt !== 3'd4) begin
      errors++;
      $display("FAIL accr_fresh got ov=%b y=%h bc=%0d exp 1 40 4",
               out_valid, y, beat_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    va = '{8'h0F, 8'h10, 8'h20, 8'h00};
    vb = '{8'h05, 8'h00, 8'h00, 8'h01};
    out_ready = 1'b1; acc_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i];
      op = (i == 0) ? 3'd2 : 3'd1;
      if (i == 0) begin
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_pass got ir=%b ov=%b exp 1 1", in_ready, out_valid);
        end
      end
      step();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0 || beat_cnt !== 3'd1) begin
          errors++;
          $display("FAIL b2b_first got ov=%b bc=%0d exp 0 1",
                   out_valid, beat_cnt);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h3B || beat_cnt !== 3'd4) begin
      errors++;
      $display("FAIL b2b_result got ov=%b y=%h bc=%0d exp 1 3b 4",
               out_valid, y, beat_cnt);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || beat_cnt !== 3'd0) begin
      errors++;
      $display("FAIL b2b_take got ov=%b bc=%0d exp 0 0", out_valid, beat_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_accumulate();
    test_acc_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
